// File: rtl/cond_status_unit.sv
// cond_status_unit
//   Consumer end of the ALU status interface. Holds the architectural
//   {N,Z,C,V} status register and returns its carry to the ALU. It evaluates
//   the ARM condition field of the ID-stage instruction and detects status
//   read-after-write hazards between the EXE and ID stages.
//
// Build option:
//   COND_STATUS_FWD_EN - when defined, EXE-stage flags are forwarded to the
//                        condition evaluator and flag_hazard is tied low.
//                        When undefined, an ID instruction that depends on
//                        in-flight flags raises a one-cycle stall request.
module cond_status_unit #(
    parameter logic [3:0] SR_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        flush,
    input  logic        exe_valid,
    input  logic        exe_s,
    input  logic [3:0]  exe_status,
    input  logic        id_valid,
    input  logic [3:0]  id_cond,
    output logic [3:0]  status_reg,
    output logic        c_in,
    output logic        cond_pass,
    output logic        flag_hazard,
    output logic [15:0] sr_wr_cnt
);

    // ARM condition field encodings
    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Bit positions inside the {N,Z,C,V} vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    logic       sr_write;
    logic       exe_sets_flags;
    logic [3:0] flags_eff;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cond_true;
    logic       hazard;
    cond_e      cond;

    // EXE-stage instruction that will update the flags
    always_comb begin
        exe_sets_flags = exe_valid & exe_s;
    end

    // Commit qualifier: a global freeze holds the architectural state
    always_comb begin
        sr_write = exe_sets_flags & ~freeze;
    end

    // Architectural status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_reg <= SR_RESET;
        end else if (sr_write) begin
            status_reg <= exe_status;
        end
    end

    // Debug count of committed status writes (wraps naturally at 16 bits)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_wr_cnt <= '0;
        end else if (sr_write) begin
            sr_wr_cnt <= sr_wr_cnt + 16'd1;
        end
    end

    // Carry-in to the ALU always comes from the registered flags
    always_comb begin
        c_in = status_reg[FLAG_C];
    end

`ifdef COND_STATUS_FWD_EN
    // Forward in-flight EXE flags so ID never sees a stale status_reg
    always_comb begin
        flags_eff = status_reg;
        if (exe_sets_flags) begin
            flags_eff = exe_status;
        end
    end

    // Forwarding resolves every flag dependency; no stall is needed
    always_comb begin
        hazard = 1'b0;
    end
`else
    // Without forwarding the evaluator only ever reads the register
    always_comb begin
        flags_eff = status_reg;
    end

    // Stall a conditional ID instruction while EXE is still producing flags.
    // Gated by rst_n so the request drops the moment reset asserts.
    always_comb begin
        hazard = 1'b0;
        if (rst_n && id_valid && !flush && exe_sets_flags &&
            (cond_e'(id_cond) != COND_AL)) begin
            hazard = 1'b1;
        end
    end
`endif

    // Split the effective flags for readability in the decoder
    always_comb begin
        flag_n = flags_eff[FLAG_N];
        flag_z = flags_eff[FLAG_Z];
        flag_c = flags_eff[FLAG_C];
        flag_v = flags_eff[FLAG_V];
        cond   = cond_e'(id_cond);
    end

    // ARM condition decode on the effective flags
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            COND_EQ: cond_true = flag_z;
            COND_NE: cond_true = ~flag_z;
            COND_CS: cond_true = flag_c;
            COND_CC: cond_true = ~flag_c;
            COND_MI: cond_true = flag_n;
            COND_PL: cond_true = ~flag_n;
            COND_VS: cond_true = flag_v;
            COND_VC: cond_true = ~flag_v;
            COND_HI: cond_true = flag_c & ~flag_z;
            COND_LS: cond_true = ~flag_c | flag_z;
            COND_GE: cond_true = (flag_n == flag_v);
            COND_LT: cond_true = (flag_n != flag_v);
            COND_GT: cond_true = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_true = flag_z | (flag_n != flag_v);
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    // Execute/annul decision; ID inputs are ignored while in reset
    always_comb begin
        cond_pass   = rst_n & id_valid & ~flush & ~hazard & cond_true;
        flag_hazard = hazard;
    end

endmodule

// File: tb/tb_cond_status_unit.sv
`timescale 1ns/1ps
module tb_cond_status_unit;

    localparam logic [3:0] SRR = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        flush;
    logic        exe_valid;
    logic        exe_s;
    logic [3:0]  exe_status;
    logic        id_valid;
    logic [3:0]  id_cond;
    logic [3:0]  status_reg;
    logic        c_in;
    logic        cond_pass;
    logic        flag_hazard;
    logic [15:0] sr_wr_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0]  sr_m;
    logic [15:0] cnt_m;

    cond_status_unit #(.SR_RESET(SRR)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .exe_valid(exe_valid), .exe_s(exe_s), .exe_status(exe_status),
        .id_valid(id_valid), .id_cond(id_cond), .status_reg(status_reg),
        .c_in(c_in), .cond_pass(cond_pass), .flag_hazard(flag_hazard),
        .sr_wr_cnt(sr_wr_cnt)
    );

    always #5 clk = ~clk;

`ifdef COND_STATUS_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // ARM conditions come in true/inverted pairs; odd codes invert the even one
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        int idx;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        idx = int'(c) / 2;
        case (idx)
            0: base = z;
            1: base = cy;
            2: base = n;
            3: base = v;
            4: base = cy && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return (int'(c) % 2 == 1) ? !base : base;
    endfunction

    function automatic logic exp_hazard();
        if (FWD || !rst_n) return 1'b0;
        return id_valid && !flush && exe_valid && exe_s && (id_cond != 4'd14);
    endfunction

    function automatic logic exp_pass();
        logic [3:0] f;
        f = (FWD && exe_valid && exe_s) ? exe_status : sr_m;
        return rst_n && id_valid && !flush && !exp_hazard() && ref_cond(id_cond, f);
    endfunction

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        logic wr;
        wr = rst_n && exe_valid && exe_s && !freeze;
        @(posedge clk);
        if (wr) begin
            sr_m  = exe_status;
            cnt_m = cnt_m + 16'd1;
        end
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        freeze = 0; flush = 0; exe_valid = 0; exe_s = 0; exe_status = '0;
        id_valid = 0; id_cond = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; sr_m = SRR; cnt_m = '0;
        tick();
        rst_n = 1;
        settle();
    endtask

    task automatic load_sr(input logic [3:0] val);
        exe_valid = 1; exe_s = 1; freeze = 0; exe_status = val;
        tick();
        exe_valid = 0; exe_s = 0;
        settle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0; sr_m = SRR; cnt_m = '0;
        id_valid = 1; id_cond = 4'b1110;
        exe_valid = 1; exe_s = 1; exe_status = 4'b1111;
        #2;
        tick();
        settle();
        checks++; if (status_reg !== 4'b0000) begin errors++; $display("FAIL reset_sr got=%b exp=0000", status_reg); end
        checks++; if (c_in !== 1'b0) begin errors++; $display("FAIL reset_cin got=%b exp=0", c_in); end
        checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b exp=0", cond_pass); end
        checks++; if (flag_hazard !== 1'b0) begin errors++; $display("FAIL reset_hz got=%b exp=0", flag_hazard); end
        checks++; if (sr_wr_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", sr_wr_cnt); end
        exe_valid = 0; exe_s = 0;
        rst_n = 1;
        settle();
        checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL release_pass got=%b exp=1", cond_pass); end
    endtask

    task automatic test_status_write();
        idle_inputs();
        exe_valid = 1; exe_s = 1; exe_status = 4'b0100;
        tick();
        settle();
        checks++; if (status_reg !== 4'b0100) begin errors++; $display("FAIL wr_sr got=%b exp=0100", status_reg); end
        checks++; if (sr_wr_cnt !== 16'd1) begin errors++; $display("FAIL wr_cnt got=%0d exp=1", sr_wr_cnt); end
        freeze = 1; exe_status = 4'b1011;
        tick();
        settle();
        checks++; if (status_reg !== 4'b0100) begin errors++; $display("FAIL freeze_sr got=%b exp=0100", status_reg); end
        checks++; if (sr_wr_cnt !== 16'd1) begin errors++; $display("FAIL freeze_cnt got=%0d exp=1", sr_wr_cnt); end
        freeze = 0; exe_s = 0; exe_status = 4'b0010;
        tick();
        settle();
        checks++; if (status_reg !== 4'b0100) begin errors++; $display("FAIL nos_sr got=%b exp=0100", status_reg); end
        checks++; if (sr_wr_cnt !== 16'd1) begin errors++; $display("FAIL nos_cnt got=%0d exp=1", sr_wr_cnt); end
        exe_valid = 1; exe_s = 1; exe_status = 4'b0010;
        tick();
        settle();
        checks++; if (c_in !== 1'b1) begin errors++; $display("FAIL cin got=%b exp=1", c_in); end
        exe_valid = 0; exe_s = 0;
    endtask

    task automatic test_cond_sweep();
        logic [3:0] vals [5];
        vals[0] = 4'b0000; vals[1] = 4'b0100; vals[2] = 4'b0010;
        vals[3] = 4'b1001; vals[4] = 4'b1000;
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            load_sr(vals[i]);
            id_valid = 1;
            for (int c = 0; c < 16; c++) begin
                id_cond = 4'(c);
                settle();
                checks++;
                if (cond_pass !== ref_cond(id_cond, vals[i])) begin
                    errors++;
                    $display("FAIL sweep sr=%b cond=%b got=%b exp=%b", vals[i], id_cond, cond_pass, ref_cond(id_cond, vals[i]));
                end
                if (c == 15) begin
                    checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL nv sr=%b got=%b exp=0", vals[i], cond_pass); end
                end
                if (vals[i] == 4'b1001 && c == 10) begin
                    checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL ge_1001 got=%b exp=1", cond_pass); end
                end
                if (vals[i] == 4'b1000 && c == 11) begin
                    checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL lt_1000 got=%b exp=1", cond_pass); end
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_forward_stall();
        idle_inputs();
        load_sr(4'b0000);
        id_valid = 1; id_cond = 4'b0000;
        exe_valid = 1; exe_s = 1; exe_status = 4'b0100;
        settle();
        if (FWD) begin
            checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL fwd_pass got=%b exp=1", cond_pass); end
            checks++; if (flag_hazard !== 1'b0) begin errors++; $display("FAIL fwd_hz got=%b exp=0", flag_hazard); end
        end else begin
            checks++; if (flag_hazard !== 1'b1) begin errors++; $display("FAIL stall_hz0 got=%b exp=1", flag_hazard); end
            checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL stall_pass0 got=%b exp=0", cond_pass); end
            tick();
            exe_valid = 0; exe_s = 0;
            settle();
            checks++; if (flag_hazard !== 1'b0) begin errors++; $display("FAIL stall_hz1 got=%b exp=0", flag_hazard); end
            checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL stall_pass1 got=%b exp=1", cond_pass); end
            exe_valid = 1; exe_s = 1;
        end
        exe_status = 4'b0000; id_cond = 4'b1110;
        settle();
        checks++; if (flag_hazard !== 1'b0) begin errors++; $display("FAIL al_hz got=%b exp=0", flag_hazard); end
        checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL al_pass got=%b exp=1", cond_pass); end
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        idle_inputs();
        load_sr(4'b0000);
        cnt_m = sr_wr_cnt === cnt_m ? cnt_m : cnt_m;
        flush = 1; id_valid = 1; id_cond = 4'b1110;
        exe_valid = 1; exe_s = 1; exe_status = 4'b0011;
        settle();
        checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL flush_pass got=%b exp=0", cond_pass); end
        checks++; if (flag_hazard !== 1'b0) begin errors++; $display("FAIL flush_hz got=%b exp=0", flag_hazard); end
        tick();
        settle();
        checks++; if (status_reg !== 4'b0011) begin errors++; $display("FAIL flush_wr got=%b exp=0011", status_reg); end
        checks++; if (sr_wr_cnt !== cnt_m) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", sr_wr_cnt, cnt_m); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        load_sr(4'b0110);
        id_valid = 1; id_cond = 4'b0000;
        exe_valid = 1; exe_s = 1; exe_status = 4'b1111;
        settle();
        checks++; if (flag_hazard !== exp_hazard()) begin errors++; $display("FAIL prestall_hz got=%b exp=%b", flag_hazard, exp_hazard()); end
        rst_n = 0; sr_m = SRR; cnt_m = '0;
        #1;
        checks++; if (flag_hazard !== 1'b0) begin errors++; $display("FAIL rststall_hz got=%b exp=0", flag_hazard); end
        checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL rststall_pass got=%b exp=0", cond_pass); end
        checks++; if (status_reg !== SRR) begin errors++; $display("FAIL rststall_sr got=%b exp=%b", status_reg, SRR); end
        tick();
        settle();
        checks++; if (status_reg !== SRR) begin errors++; $display("FAIL rststall_nowr got=%b exp=%b", status_reg, SRR); end
        checks++; if (sr_wr_cnt !== 16'd0) begin errors++; $display("FAIL rststall_cnt got=%0d exp=0", sr_wr_cnt); end
        rst_n = 1;
        idle_inputs();
        settle();
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            freeze     = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 5) == 0);
            exe_valid  = ($urandom_range(0, 3) != 0);
            exe_s      = $urandom_range(0, 1);
            exe_status = 4'($urandom);
            id_valid   = ($urandom_range(0, 4) != 0);
            id_cond    = 4'($urandom);
            settle();
            checks++; if (cond_pass !== exp_pass()) begin errors++; $display("FAIL rnd_pass i=%0d got=%b exp=%b", i, cond_pass, exp_pass()); end
            checks++; if (flag_hazard !== exp_hazard()) begin errors++; $display("FAIL rnd_hz i=%0d got=%b exp=%b", i, flag_hazard, exp_hazard()); end
            checks++; if (status_reg !== sr_m) begin errors++; $display("FAIL rnd_sr i=%0d got=%b exp=%b", i, status_reg, sr_m); end
            checks++; if (c_in !== sr_m[1]) begin errors++; $display("FAIL rnd_cin i=%0d got=%b exp=%b", i, c_in, sr_m[1]); end
            checks++; if (sr_wr_cnt !== cnt_m) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, sr_wr_cnt, cnt_m); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_counter_wrap();
        idle_inputs();
        do_reset();
        exe_valid = 1; exe_s = 1;
        for (int i = 0; i < 65535; i++) begin
            exe_status = 4'($urandom);
            tick();
        end
        settle();
        checks++; if (sr_wr_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_max got=%h exp=ffff", sr_wr_cnt); end
        checks++; if (status_reg !== sr_m) begin errors++; $display("FAIL cnt_sr got=%b exp=%b", status_reg, sr_m); end
        exe_status = 4'b1010;
        tick();
        settle();
        checks++; if (sr_wr_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got=%h exp=0000", sr_wr_cnt); end
        checks++; if (status_reg !== 4'b1010) begin errors++; $display("FAIL wrap_sr got=%b exp=1010", status_reg); end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        sr_m = SRR; cnt_m = '0;
        test_reset();
        test_status_write();
        test_cond_sweep();
        test_forward_stall();
        test_flush();
        test_reset_mid_stall();
        test_random();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
